// File: rtl/serial_addsub_nb.sv
// Bit-serial adder/subtractor with parallel result and accumulate-in-place.
//
// Operands are shifted in LSB first while idle. After start, one result bit
// is produced per clock. Each result bit is shifted back into the A register,
// so A holds the parallel result when the operation ends. B rotates and is
// restored after WIDTH cycles, so a later start without a reload computes
// result +/- B.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-low
//   load    shift SI_1/SI_2 into A/B (LSB first); honoured in IDLE only
//   SI_1    serial operand A bit
//   SI_2    serial operand B bit
//   start   begin an operation; honoured in IDLE when load is low
//   sub     0: A+B, 1: A-B; latched when start is accepted
//   Sum     registered serial result bit, LSB first
//   Cy      final carry-out (subtract: 1 = no borrow)
//   result  parallel result (the A register)
//   ovf     two's-complement overflow of the last operation
//   busy    high while an operation is in progress (RUN and DONE)
//   done    one-cycle pulse when an operation completes
module serial_addsub_nb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             SI_1,
  input  logic             SI_2,
  input  logic             start,
  input  logic             sub,
  output logic             Sum,
  output logic             Cy,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_l;
  logic             cin_msb;

  logic do_load, do_start, do_step, do_finish;
  logic b_bit, s_bit, c_next, last;

  assign result = a_reg;

  // Subtraction is A + ~B + 1: invert B per bit and seed the carry with sub.
  assign b_bit  = b_reg[0] ^ sub_l;
  assign s_bit  = a_reg[0] ^ b_bit ^ carry;
  assign c_next = (a_reg[0] & b_bit) | (a_reg[0] & carry) | (b_bit & carry);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_start   = 1'b0;
    do_step    = 1'b0;
    do_finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          do_load = 1'b1;
        end else if (start) begin
          do_start   = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        do_step = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        do_finish  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sub_l   <= 1'b0;
      cin_msb <= 1'b0;
      Sum     <= 1'b0;
      Cy      <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_load) begin
        a_reg <= {SI_1, a_reg[WIDTH-1:1]};
        b_reg <= {SI_2, b_reg[WIDTH-1:1]};
      end
      if (do_start) begin
        sub_l <= sub;
        carry <= sub;
        cnt   <= '0;
        busy  <= 1'b1;
      end
      if (do_step) begin
        carry <= c_next;
        Sum   <= s_bit;
        a_reg <= {s_bit, a_reg[WIDTH-1:1]};
        b_reg <= {b_reg[0], b_reg[WIDTH-1:1]};
        cnt   <= cnt + CW'(1);
        // Carry into the MSB position, kept for the overflow flag.
        if (last) cin_msb <= carry;
      end
      if (do_finish) begin
        Cy   <= carry;
        ovf  <= cin_msb ^ carry;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_nb.sv
// Self-checking bench for serial_addsub_nb at WIDTH=4: directed vectors plus
// randomized operations checked against an integer-arithmetic reference.
module tb_serial_addsub_nb;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, load, SI_1, SI_2, start, sub;
  logic         Sum, Cy, ovf, busy, done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  // Reference state: what A and B should hold.
  logic [W-1:0] ma, mb;

  serial_addsub_nb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .SI_1(SI_1), .SI_2(SI_2),
    .start(start), .sub(sub), .Sum(Sum), .Cy(Cy), .result(result),
    .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Plain arithmetic: unsigned sum for result/carry, signed range for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] r,
                                output logic cy, output logic ov);
    int unsigned full;
    int sa, sb, sr;
    if (s) full = 32'(a) + 32'((~b) & 4'hF) + 32'd1;
    else   full = 32'(a) + 32'(b);
    r  = 4'(full);
    cy = full[4];
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    sr = s ? sa - sb : sa + sb;
    ov = (sr > 7) || (sr < -8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < int'(W); i++) begin
      load = 1'b1; SI_1 = a[i]; SI_2 = b[i];
      tick();
    end
    load = 1'b0;
    ma = a; mb = b;
  endtask

  // Accepts start on the next edge, collects the Sum stream and measures
  // how many edges after the start edge the done pulse appears.
  task automatic do_op(input logic s, output logic [W-1:0] sums,
                       output int lat, output int ndone);
    sub = s; start = 1'b1;
    tick();
    start = 1'b0; sub = $urandom_range(0, 1);
    lat = -1; ndone = 0; sums = '0;
    for (int cyc = 1; cyc <= int'(W) + 4; cyc++) begin
      tick();
      if (cyc <= int'(W)) sums[cyc-1] = Sum;
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load = $urandom_range(0, 1); start = $urandom_range(0, 1);
      sub = $urandom_range(0, 1); SI_1 = $urandom_range(0, 1); SI_2 = $urandom_range(0, 1);
      tick();
    end
    checks++;
    if ({Sum, Cy, ovf, busy, done, result} !== 9'b0) begin
      errors++;
      $display("FAIL reset got %b exp %b", {Sum, Cy, ovf, busy, done, result}, 9'b0);
    end
    rst = 1'b1; load = 1'b0; start = 1'b0; sub = 1'b0;
    ma = '0; mb = '0;
  endtask

  task automatic test_add();
    logic [W-1:0] sums; int lat, nd;
    load_ops(4'b1011, 4'b0110);
    checks++;
    if (result !== 4'b1011) begin
      errors++; $display("FAIL add_loaded got %b exp %b", result, 4'b1011);
    end
    do_op(1'b0, sums, lat, nd);
    checks++;
    if (sums !== 4'b0001) begin
      errors++; $display("FAIL add_sum_stream got %b exp %b", sums, 4'b0001);
    end
    checks++;
    if ({result, Cy, ovf} !== {4'b0001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_result got %b exp %b", {result, Cy, ovf}, 6'b000110);
    end
    checks++;
    if (lat != 5 || nd != 1) begin
      errors++; $display("FAIL add_done_timing got lat=%0d n=%0d exp lat=5 n=1", lat, nd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_busy_after got %b exp 0", busy);
    end
    ma = 4'b0001;
  endtask

  task automatic test_accumulate();
    logic [W-1:0] sums; int lat, nd;
    do_op(1'b0, sums, lat, nd);
    checks++;
    if ({result, Cy} !== {4'b0111, 1'b0}) begin
      errors++; $display("FAIL accum_result got %b exp %b", {result, Cy}, 5'b01110);
    end
    // B must still be 0110: a third add gives 7+6=13.
    do_op(1'b0, sums, lat, nd);
    checks++;
    if ({result, Cy, ovf} !== {4'b1101, 1'b0, 1'b1}) begin
      errors++; $display("FAIL accum_b_kept got %b exp %b", {result, Cy, ovf}, 6'b110101);
    end
    ma = 4'b1101;
  endtask

  task automatic test_sub();
    logic [W-1:0] sums; int lat, nd;
    load_ops(4'b0101, 4'b0011);
    do_op(1'b1, sums, lat, nd);
    checks++;
    if ({result, Cy} !== {4'b0010, 1'b1} || sums !== 4'b0010) begin
      errors++; $display("FAIL sub_5m3 got %b/%b exp 00101/0010", {result, Cy}, sums);
    end
    load_ops(4'b0011, 4'b0101);
    do_op(1'b1, sums, lat, nd);
    checks++;
    if ({result, Cy, ovf} !== {4'b1110, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_3m5 got %b exp %b", {result, Cy, ovf}, 6'b111000);
    end
    ma = 4'b1110;
  endtask

  task automatic test_overflow();
    logic [W-1:0] sums; int lat, nd;
    load_ops(4'b0111, 4'b0001);
    do_op(1'b0, sums, lat, nd);
    checks++;
    if ({result, Cy, ovf} !== {4'b1000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL ovf_add got %b exp %b", {result, Cy, ovf}, 6'b100001);
    end
    ma = 4'b1000;
  endtask

  task automatic test_reset_mid_run();
    int nd = 0;
    load_ops(4'b0110, 4'b0011);
    start = 1'b1; tick(); start = 1'b0;
    tick();                     // first RUN edge
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if ({busy, result, done} !== 6'b0) begin
      errors++; $display("FAIL midrun_reset got %b exp %b", {busy, result, done}, 6'b0);
    end
    for (int i = 0; i < int'(W) + 3; i++) begin
      tick();
      if (done) nd++;
    end
    checks++;
    if (nd != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_no_done got n=%0d busy=%b exp n=0 busy=0", nd, busy);
    end
    ma = '0; mb = '0;
  endtask

  task automatic test_busy_ignore();
    int nd = 0, lat = -1;
    load_ops(4'b0010, 4'b0011);
    sub = 1'b0; start = 1'b1; tick();
    for (int cyc = 1; cyc <= int'(W) + 4; cyc++) begin
      // Keep hammering load and start while the operation runs.
      start = 1'b1; load = 1'b1; SI_1 = $urandom_range(0, 1); SI_2 = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      if (cyc > int'(W) + 1) begin start = 1'b0; load = 1'b0; end
      tick();
      if (done) begin nd++; if (lat < 0) lat = cyc; end
    end
    start = 1'b0; load = 1'b0;
    checks++;
    if ({result, Cy, ovf} !== {4'b0101, 1'b0, 1'b0} || lat != 5 || nd != 1) begin
      errors++;
      $display("FAIL busy_ignore got %b lat=%0d n=%0d exp 010100 lat=5 n=1",
               {result, Cy, ovf}, lat, nd);
    end
    ma = 4'b0101;
  endtask

  task automatic test_load_start();
    logic [W-1:0] sums; int lat, nd;
    logic [W-1:0] a = 4'b1001, b = 4'b0100;
    for (int i = 0; i < int'(W); i++) begin
      load = 1'b1; start = 1'b1; SI_1 = a[i]; SI_2 = b[i];
      tick();
    end
    load = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== a) begin
      errors++; $display("FAIL load_priority got busy=%b res=%b exp busy=0 res=%b", busy, result, a);
    end
    do_op(1'b0, sums, lat, nd);
    checks++;
    if (result !== 4'b1101 || sums !== 4'b1101) begin
      errors++; $display("FAIL load_priority_op got %b/%b exp 1101/1101", result, sums);
    end
    ma = 4'b1101; mb = b;
  endtask

  task automatic test_random();
    logic [W-1:0] sums, er; logic ecy, eov, s; int lat, nd;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) != 0) load_ops(4'($urandom), 4'($urandom));
      s = $urandom_range(0, 1);
      model(ma, mb, s, er, ecy, eov);
      do_op(s, sums, lat, nd);
      checks++;
      if ({result, Cy, ovf} !== {er, ecy, eov} || sums !== er || lat != 5 || nd != 1) begin
        errors++;
        $display("FAIL random_%0d a=%b b=%b sub=%b got %b sums=%b lat=%0d exp %b lat=5",
                 n, ma, mb, s, {result, Cy, ovf}, sums, lat, {er, ecy, eov});
      end
      ma = er;
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; start = 1'b0; sub = 1'b0; SI_1 = 1'b0; SI_2 = 1'b0;
    test_reset();
    test_add();
    test_accumulate();
    test_sub();
    test_overflow();
    test_reset_mid_run();
    test_busy_ignore();
    test_load_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
